// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C temperature read sequencer.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        RD_BYTE,
        M_ACK,
        STOP_LOW,
        STOP,
        DONE
    } i2c_state_t;

    localparam logic I2C_READ_BIT   = 1'b1;
    localparam int   BYTES_PER_READ = 2;
    localparam int   DATA_W         = 8 * BYTES_PER_READ;
    localparam int   DIV_W          = 10;

endpackage

// File: rtl/i2c_temp_reader_if.sv
// Handshake, divider control and open-drain pin signals of the temperature reader.
interface i2c_temp_reader_if;
    import i2c_pkg::*;

    logic              req;
    logic              busy;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ack_error;
    logic              clk_cs;
    logic [DIV_W-1:0]  clk_divisor;
    logic              scl_in;
    logic              scl_oe;
    logic              sda_oe;
    logic              sda_in;

    modport master (
        input  req, scl_in, sda_in,
        output busy, valid, data, ack_error, clk_cs, clk_divisor, scl_oe, sda_oe
    );

    modport slave (
        output req, scl_in, sda_in,
        input  busy, valid, data, ack_error, clk_cs, clk_divisor, scl_oe, sda_oe
    );

endinterface

// File: rtl/i2c_tick_detect.sv
// Half-period tick: any level change on the divider output while the divider is enabled.
module i2c_tick_detect (
    input  logic in_clock,
    input  logic reset,
    input  logic scl_in,
    input  logic clk_cs,
    output logic tick
);

    logic scl_q;

    always_ff @(posedge in_clock or posedge reset) begin
        if (reset) begin
            scl_q <= 1'b0;
        end else begin
            scl_q <= scl_in;
        end
    end

    assign tick = (scl_in != scl_q) && clk_cs;

endmodule

// File: rtl/i2c_temp_reader.sv
// Sequences one two-byte I2C read (START, addr+R, 2 data bytes, STOP) using divider
// level changes as half-period ticks; drives the open-drain SCL/SDA enables directly.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | bus released, waiting for req
//   START    | SDA pulled low with SCL high until the first tick
//   ADDR     | shifting out {DEV_ADDR, R}, MSB first
//   ADDR_ACK | sampling the slave acknowledge
//   RD_BYTE  | shifting in one data byte on rising SCL
//   M_ACK    | master ACK after byte 0, NACK after the last byte
//   STOP_LOW | SDA held low while SCL returns high
//   STOP     | SDA released with SCL high (STOP condition)
//   DONE     | one-cycle valid pulse, then back to IDLE
module i2c_temp_reader
    import i2c_pkg::*;
#(
    parameter logic [6:0]       DEV_ADDR = 7'h48,
    parameter logic [DIV_W-1:0] DIVISOR  = 10'd248
) (
    input  logic               in_clock,
    input  logic               reset,
    i2c_temp_reader_if.master  bus
);

    localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, I2C_READ_BIT};

    i2c_state_t        state;
    logic              tick;
    logic              rise;
    logic              fall;
    logic              scl;
    logic              sda_oe;
    logic              clk_cs;
    logic              busy;
    logic              valid;
    logic              ack_error;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] rx_shift;
    logic [7:0]        tx_shift;
    logic [2:0]        bitcnt;
    logic [2:0]        bitcnt_dec;
    logic              bytecnt;

    i2c_tick_detect u_tick_detect (
        .in_clock (in_clock),
        .reset    (reset),
        .scl_in   (bus.scl_in),
        .clk_cs   (clk_cs),
        .tick     (tick)
    );

    // scl is the level this block is driving; a tick moves it to the opposite level.
    assign rise       = tick && !scl;
    assign fall       = tick && scl;
    assign bitcnt_dec = bitcnt - 3'd1;

    always_ff @(posedge in_clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            scl       <= 1'b1;
            sda_oe    <= 1'b0;
            clk_cs    <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            ack_error <= 1'b0;
            data      <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            bitcnt    <= 3'd0;
            bytecnt   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        sda_oe    <= 1'b1;
                        clk_cs    <= 1'b1;
                        busy      <= 1'b1;
                        ack_error <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        scl      <= 1'b0;
                        tx_shift <= ADDR_BYTE;
                        bitcnt   <= 3'd7;
                        sda_oe   <= ~ADDR_BYTE[7];
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (rise) begin
                        scl <= 1'b1;
                    end else if (fall) begin
                        scl <= 1'b0;
                        if (bitcnt == 3'd0) begin
                            sda_oe <= 1'b0;
                            state  <= ADDR_ACK;
                        end else begin
                            bitcnt <= bitcnt_dec;
                            sda_oe <= ~tx_shift[bitcnt_dec];
                        end
                    end
                end
                ADDR_ACK: begin
                    // Sample on the rising tick, but leave only on the falling tick so the
                    // following state always starts with SCL low.
                    if (rise) begin
                        scl       <= 1'b1;
                        ack_error <= bus.sda_in;
                    end else if (fall) begin
                        scl <= 1'b0;
                        if (ack_error) begin
                            sda_oe <= 1'b1;
                            state  <= STOP_LOW;
                        end else begin
                            bitcnt  <= 3'd7;
                            bytecnt <= 1'b0;
                            state   <= RD_BYTE;
                        end
                    end
                end
                RD_BYTE: begin
                    if (rise) begin
                        scl      <= 1'b1;
                        rx_shift <= {rx_shift[DATA_W-2:0], bus.sda_in};
                    end else if (fall) begin
                        scl <= 1'b0;
                        if (bitcnt == 3'd0) begin
                            sda_oe <= ~bytecnt;
                            state  <= M_ACK;
                        end else begin
                            bitcnt <= bitcnt_dec;
                        end
                    end
                end
                M_ACK: begin
                    if (rise) begin
                        scl <= 1'b1;
                    end else if (fall) begin
                        scl <= 1'b0;
                        if (!bytecnt) begin
                            bytecnt <= 1'b1;
                            bitcnt  <= 3'd7;
                            sda_oe  <= 1'b0;
                            state   <= RD_BYTE;
                        end else begin
                            sda_oe <= 1'b1;
                            state  <= STOP_LOW;
                        end
                    end
                end
                STOP_LOW: begin
                    if (rise) begin
                        scl   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        sda_oe <= 1'b0;
                        clk_cs <= 1'b0;
                        valid  <= 1'b1;
                        if (!ack_error) begin
                            data <= rx_shift;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.valid       = valid;
    assign bus.data        = data;
    assign bus.ack_error   = ack_error;
    assign bus.clk_cs      = clk_cs;
    assign bus.clk_divisor = DIVISOR;
    assign bus.scl_oe      = ~scl;
    assign bus.sda_oe      = sda_oe;

endmodule

// File: tb/tb_i2c_temp_reader.sv
// Randomized scoreboard bench: divider and sensor models on the open-drain bus.
module tb_i2c_temp_reader;

    localparam logic [9:0] TB_DIV   = 10'd6;
    localparam logic [6:0] TB_ADDR  = 7'h48;
    localparam logic [7:0] ADDR_RD  = {TB_ADDR, 1'b1};
    localparam int         TXN_MAX  = 2000;

    typedef struct {
        bit         present;
        logic [7:0] b0;
        logic [7:0] b1;
    } slv_cfg_t;

    typedef struct {
        logic [15:0] data;
        bit          ack_err;
        int          ticks;
        bit          present;
    } exp_t;

    logic in_clock;
    logic reset;
    logic req;
    logic slv_oe;
    logic scl_line;
    logic sda_line;
    logic div_out;
    logic idle_level;
    logic [10:0] div_cnt;

    int checks = 0;
    int errors = 0;

    slv_cfg_t    slv_q[$];
    exp_t        exp_q[$];
    logic [15:0] ref_data;

    i2c_temp_reader_if bus();

    i2c_temp_reader #(.DEV_ADDR(TB_ADDR), .DIVISOR(TB_DIV)) dut (
        .in_clock (in_clock),
        .reset    (reset),
        .bus      (bus)
    );

    assign bus.req    = req;
    assign bus.scl_in = div_out;
    assign scl_line   = ~bus.scl_oe;
    assign sda_line   = ~(bus.sda_oe | slv_oe);
    assign bus.sda_in = sda_line;

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic int exp_ticks(input bit present);
        return 1 + 2 * (8 + 1) + (present ? 2 * 2 * (8 + 1) : 0) + 2;
    endfunction

    // ---------------- divider model: toggles every DIVISOR+2 cycles while enabled
    initial begin
        div_out = 1'b0;
        div_cnt = '0;
    end
    always @(posedge in_clock) begin
        if (!bus.clk_cs) begin
            div_cnt <= '0;
            div_out <= idle_level;
        end else if (div_cnt == {1'b0, bus.clk_divisor} + 11'd1) begin
            div_cnt <= '0;
            div_out <= ~div_out;
        end else begin
            div_cnt <= div_cnt + 11'd1;
        end
    end

    // ---------------- sensor model
    typedef enum {S_IDLE, S_ADDR, S_AACK, S_ACKING, S_TX, S_MACK, S_WAIT} sph_t;
    sph_t       sph = S_IDLE;
    int         sbit = 0;
    int         sbyte = 0;
    logic [7:0] sreg = 8'h00;
    logic [7:0] addr_seen = 8'h00;
    logic [1:0] mack_seen = 2'b01;
    slv_cfg_t   cur;
    logic       s_scl = 1'b1;
    logic       s_sda = 1'b1;

    initial slv_oe = 1'b0;

    always @(negedge in_clock) begin
        logic [7:0] cb;
        cb = (sbyte == 0) ? cur.b0 : cur.b1;
        if (scl_line && s_scl && s_sda && !sda_line) begin
            sph = S_ADDR;
            sbit = 0;
            slv_oe = 1'b0;
            mack_seen = 2'b01;
            if (slv_q.size() > 0) cur = slv_q.pop_front();
            else cur = '{present: 1'b0, b0: 8'h00, b1: 8'h00};
        end else if (scl_line && s_scl && !s_sda && sda_line) begin
            sph = S_IDLE;
            slv_oe = 1'b0;
        end else if (scl_line && !s_scl) begin
            if (sph == S_ADDR) begin
                sreg = {sreg[6:0], sda_line};
                sbit++;
                if (sbit == 8) begin
                    addr_seen = sreg;
                    sph = S_AACK;
                end
            end else if (sph == S_MACK) begin
                mack_seen[sbyte] = sda_line;
            end
        end else if (!scl_line && s_scl) begin
            case (sph)
                S_AACK: begin
                    if (cur.present && addr_seen == ADDR_RD) begin
                        slv_oe = 1'b1;
                        sph = S_ACKING;
                    end else begin
                        sph = S_WAIT;
                    end
                end
                S_ACKING: begin
                    sbyte = 0;
                    sbit = 0;
                    slv_oe = ~cur.b0[7];
                    sph = S_TX;
                end
                S_TX: begin
                    sbit++;
                    if (sbit == 8) begin
                        slv_oe = 1'b0;
                        sph = S_MACK;
                    end else begin
                        slv_oe = ~cb[7 - sbit];
                    end
                end
                S_MACK: begin
                    if (sbyte == 0 && mack_seen[0] == 1'b0) begin
                        sbyte = 1;
                        sbit = 0;
                        slv_oe = ~cur.b1[7];
                        sph = S_TX;
                    end else begin
                        slv_oe = 1'b0;
                        sph = S_WAIT;
                    end
                end
                default: ;
            endcase
        end
        s_scl = scl_line;
        s_sda = sda_line;
    end

    // ---------------- monitor / scoreboard
    int         cyc = 0;
    int         tick_cnt = 0;
    int         last_tick_cyc = 0;
    int         starts = 0;
    int         stops = 0;
    bit         recording = 0;
    logic       m_busy = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       m_div = 1'b0;
    logic [1:0] wave_cur[$];
    logic [1:0] wave_last[$];
    logic [1:0] wave_prev[$];

    always @(negedge in_clock) begin
        exp_t e;
        cyc++;
        if (bus.busy === 1'b1 && !m_busy) begin
            tick_cnt = 0;
            starts = 0;
            stops = 0;
            recording = 0;
            wave_cur.delete();
        end
        if (scl_line && m_scl && m_sda && !sda_line) starts++;
        if (scl_line && m_scl && !m_sda && sda_line) stops++;
        if (div_out != m_div && bus.clk_cs === 1'b1) begin
            tick_cnt++;
            last_tick_cyc = cyc;
            recording = 1;
        end
        if (recording) wave_cur.push_back({scl_line, sda_line});
        if (m_valid) check("valid_width", bus.valid, 0);
        if (bus.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: valid with no pending request, data %0h", bus.data);
            end else begin
                e = exp_q.pop_front();
                check("data", bus.data, e.data);
                check("ack_error", bus.ack_error, e.ack_err);
                check("tick_count", tick_cnt, e.ticks);
                check("valid_latency", cyc - last_tick_cyc, 1);
                check("start_count", starts, 1);
                check("stop_count", stops, 1);
                check("clk_cs_at_valid", bus.clk_cs, 0);
                check("addr_byte", addr_seen, ADDR_RD);
                if (e.present) check("master_ack_nack", mack_seen, 2'b10);
            end
            recording = 0;
            wave_prev = wave_last;
            wave_last = wave_cur;
        end
        m_busy = (bus.busy === 1'b1);
        m_valid = (bus.valid === 1'b1);
        m_scl = scl_line;
        m_sda = sda_line;
        m_div = div_out;
    end

    // ---------------- stimulus
    task automatic push_txn(input bit present, input logic [7:0] b0, input logic [7:0] b1);
        slv_q.push_back('{present: present, b0: b0, b1: b1});
        if (present) ref_data = {b0, b1};
        exp_q.push_back('{data: ref_data, ack_err: !present, ticks: exp_ticks(present), present: present});
    endtask

    task automatic issue(input bit present, input logic [7:0] b0, input logic [7:0] b1);
        push_txn(present, b0, b1);
        req = 1'b1;
        @(negedge in_clock);
        req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < TXN_MAX) begin
            @(negedge in_clock);
            n++;
        end
        if (n >= TXN_MAX) bound_fail(name);
    endtask

    task automatic set_phase(input logic lvl);
        idle_level = lvl;
        repeat (3) @(negedge in_clock);
    endtask

    initial begin
        int n;
        int ndiff;
        reset = 1'b1;
        req = 1'b0;
        idle_level = 1'b0;
        ref_data = 16'h0000;
        repeat (3) @(negedge in_clock);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_data", bus.data, 0);
        check("rst_ack_error", bus.ack_error, 0);
        check("rst_clk_cs", bus.clk_cs, 0);
        check("rst_scl_oe", bus.scl_oe, 0);
        check("rst_sda_oe", bus.sda_oe, 0);
        check("clk_divisor", bus.clk_divisor, TB_DIV);
        reset = 1'b0;
        repeat (2) @(negedge in_clock);

        // nominal read, then identical read with the opposite divider idle phase
        set_phase(1'b0);
        issue(1'b1, 8'h19, 8'h80);
        wait_done("nominal");
        set_phase(1'b1);
        issue(1'b1, 8'h19, 8'h80);
        wait_done("phase");
        check("phase_wave_len", wave_last.size(), wave_prev.size());
        ndiff = 0;
        for (int i = 0; i < wave_last.size() && i < wave_prev.size(); i++)
            if (wave_last[i] !== wave_prev[i]) ndiff++;
        check("phase_wave_diff", ndiff, 0);

        // sensor absent: NACK, data retained
        issue(1'b0, 8'hA5, 8'h5A);
        wait_done("nack");

        // randomized reads
        for (int k = 0; k < 6; k++) begin
            set_phase(1'($urandom_range(0, 1)));
            issue($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
            wait_done("random");
        end

        // req pulsed while busy is ignored
        issue(1'b1, 8'($urandom), 8'($urandom));
        repeat ($urandom_range(20, 300)) @(negedge in_clock);
        req = 1'b1;
        @(negedge in_clock);
        req = 1'b0;
        wait_done("busy_req");
        repeat (4) @(negedge in_clock);
        check("req_busy_ignored", bus.busy, 0);

        // req held: back-to-back with one idle cycle
        push_txn(1'b1, 8'($urandom), 8'($urandom));
        push_txn(1'b1, 8'($urandom), 8'($urandom));
        req = 1'b1;
        n = 0;
        while (bus.valid !== 1'b1 && n < TXN_MAX) begin
            @(negedge in_clock);
            n++;
        end
        if (n >= TXN_MAX) bound_fail("held_first_valid");
        @(negedge in_clock);
        check("held_gap_busy_low", bus.busy, 0);
        @(negedge in_clock);
        check("held_restart_busy", bus.busy, 1);
        req = 1'b0;
        wait_done("held");
        repeat (4) @(negedge in_clock);
        check("held_no_third", bus.busy, 0);

        // reset in the middle of the address phase
        slv_q.push_back('{present: 1'b1, b0: 8'h12, b1: 8'h34});
        req = 1'b1;
        @(negedge in_clock);
        req = 1'b0;
        n = 0;
        while (tick_cnt < 5 && n < TXN_MAX) begin
            @(negedge in_clock);
            n++;
        end
        if (n >= TXN_MAX) bound_fail("mid_addr_wait");
        reset = 1'b1;
        @(negedge in_clock);
        check("midrst_scl_oe", bus.scl_oe, 0);
        check("midrst_sda_oe", bus.sda_oe, 0);
        check("midrst_clk_cs", bus.clk_cs, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_data", bus.data, 0);
        ref_data = 16'h0000;
        repeat (3) @(negedge in_clock);
        reset = 1'b0;
        repeat (3) @(negedge in_clock);
        issue(1'b1, 8'($urandom), 8'($urandom));
        wait_done("after_reset");

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
